// File: rtl/fifo_mem_ctrl_if.sv
// Stream and memory-port bundle for fifo_mem_ctrl.
// The master modport is the controller; the slave modport is the producer/consumer/memory side.
interface fifo_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              mem_en;
    logic              mem_rd_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    modport master (
        input  wr_valid, wr_data, rd_ready, mem_rd_data,
        output wr_ready, rd_valid, rd_data, mem_en, mem_rd_wr, mem_addr, mem_wr_data
    );

    modport slave (
        output wr_valid, wr_data, rd_ready, mem_rd_data,
        input  wr_ready, rd_valid, rd_data, mem_en, mem_rd_wr, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/fifo_mem_ctrl.sv
// FIFO controller over a single-port synchronous memory with a prefetched output register.
// Define FMC_LEVEL_EN to add the registered occupancy port `level`.
module fifo_mem_ctrl #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_mem_ctrl_if.master     bus
`ifdef FMC_LEVEL_EN
    ,
    output logic [ADDR_W+1:0]   level
`endif
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  mem_cnt;
    logic              rd_pending;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    logic rd_issue;
    logic wr_ready_int;
    logic push;
    logic pop;

    // A read is issued whenever memory has data and the output register will be free to take it.
    assign rd_issue     = rst_n && (mem_cnt != '0) && !rd_pending && (!out_valid || bus.rd_ready);
    assign wr_ready_int = rst_n && (mem_cnt != CNT_W'(DEPTH)) && !rd_issue;
    assign push         = bus.wr_valid && wr_ready_int;
    assign pop          = out_valid && bus.rd_ready;

    assign bus.wr_ready = wr_ready_int;
    assign bus.rd_valid = out_valid;
    assign bus.rd_data  = out_data;

    // Memory port arbitration: reads win, writes use the remaining cycles.
    always_comb begin
        bus.mem_en      = 1'b0;
        bus.mem_rd_wr   = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        if (rd_issue) begin
            bus.mem_en    = 1'b1;
            bus.mem_rd_wr = 1'b1;
            bus.mem_addr  = rd_ptr;
        end else if (push) begin
            bus.mem_en      = 1'b1;
            bus.mem_addr    = wr_ptr;
            bus.mem_wr_data = bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_cnt    <= '0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= rd_issue;
            if (rd_issue) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                mem_cnt <= mem_cnt - CNT_W'(1);
            end else if (push) begin
                wr_ptr  <= wr_ptr + ADDR_W'(1);
                mem_cnt <= mem_cnt + CNT_W'(1);
            end
        end
    end

    // Output register: a returning read overrides a same-cycle pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (rd_pending) begin
            out_valid <= 1'b1;
            out_data  <= bus.mem_rd_data;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FMC_LEVEL_EN
    // Total occupancy moves only on accepted pushes and pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            level <= level + (ADDR_W+2)'(push) - (ADDR_W+2)'(pop);
        end
    end
`endif

endmodule
